// File: rtl/axi_lite_pkg.sv
// Shared response type and address helpers for the parametrised AXI-Lite register file.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int idx_width(input int num_regs);
    return $clog2(num_regs);
  endfunction

  // The full address takes part in the compare, so aliases above the decoded window are rejected.
  function automatic logic addr_in_range(input logic [63:0] addr, input int num_regs,
                                         input int data_width);
    return addr < (64'(num_regs) * 64'(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bus bundle (AW/W/B/AR/R) with slave and master views.
interface AXI_LITE #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_valid;
  logic                    r_ready;

  modport Slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport Master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axi_lite_hold_reg.sv
// One-entry valid/ready holding register: parks a handshaken payload until the consumer takes it.
module axi_lite_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             consume_i,
  output logic             avail_o,
  output logic [WIDTH-1:0] data_o
);

  logic             held_q, held_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign ready_o = !held_q && !rst_i;
  assign avail_o = held_q || (valid_i && ready_o);
  assign data_o  = held_q ? data_q : data_i;

  // A same-cycle handshake and consume passes straight through without being parked.
  always_comb begin
    held_d = held_q;
    data_d = data_q;
    if (consume_i) begin
      held_d = 1'b0;
    end else if (valid_i && ready_o) begin
      held_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      held_q <= 1'b0;
      data_q <= '0;
    end else begin
      held_q <= held_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI-Lite slave register file with byte strobes, read-only status slots and per-register access pulses.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  AXI_LITE.Slave                         axi_l,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_data_i,
  output logic [NUM_REGS-1:0]            wr_pulse_o,
  output logic [NUM_REGS-1:0]            rd_pulse_o
);

  localparam int ADDRLSB = addr_lsb(DATA_WIDTH);
  localparam int IW      = idx_width(NUM_REGS);
  localparam int NB      = DATA_WIDTH / 8;

  logic                     aw_ready, w_ready, ar_ready;
  logic                     aw_avail, w_avail, commit, ar_hs;
  logic [ADDR_WIDTH-1:0]    waddr;
  logic [NB+DATA_WIDTH-1:0] w_payload_in, w_payload;
  logic [DATA_WIDTH-1:0]    wdata;
  logic [NB-1:0]            wstrb;
  logic [IW-1:0]            widx, ridx;
  logic                     w_ok, r_in_range;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] hw_arr [NUM_REGS];

  logic                  b_valid_q, b_valid_d;
  resp_t                 b_resp_q, b_resp_d;
  logic                  r_valid_q, r_valid_d;
  resp_t                 r_resp_q, r_resp_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;

  assign commit       = aw_avail && w_avail && (!b_valid_q || axi_l.b_ready);
  assign w_payload_in = {axi_l.w_strb, axi_l.w_data};
  assign {wstrb, wdata} = w_payload;

  axi_lite_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (axi_l.aw_valid),
    .ready_o   (aw_ready),
    .data_i    (axi_l.aw_addr),
    .consume_i (commit),
    .avail_o   (aw_avail),
    .data_o    (waddr)
  );

  axi_lite_hold_reg #(.WIDTH(NB + DATA_WIDTH)) u_w_hold (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (axi_l.w_valid),
    .ready_o   (w_ready),
    .data_i    (w_payload_in),
    .consume_i (commit),
    .avail_o   (w_avail),
    .data_o    (w_payload)
  );

  assign widx       = waddr[ADDRLSB +: IW];
  assign w_ok       = addr_in_range(64'(waddr), NUM_REGS, DATA_WIDTH) && !RO_MASK[widx];
  assign ridx       = axi_l.ar_addr[ADDRLSB +: IW];
  assign r_in_range = addr_in_range(64'(axi_l.ar_addr), NUM_REGS, DATA_WIDTH);
  assign ar_ready   = (!r_valid_q || axi_l.r_ready) && !rst_i;
  assign ar_hs      = axi_l.ar_valid && ar_ready;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slots
    assign hw_arr[i]                           = hw_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
  end

  // Rejected writes still complete on B, just with SLVERR and no side effects.
  always_comb begin
    regs_d     = regs_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    wr_pulse_d = '0;
    if (commit) begin
      b_valid_d = 1'b1;
      b_resp_d  = w_ok ? OKAY : SLVERR;
      if (w_ok) begin
        wr_pulse_d[widx] = 1'b1;
        for (int k = 0; k < NB; k++) begin
          if (wstrb[k]) regs_d[widx][8*k +: 8] = wdata[8*k +: 8];
        end
      end
    end else if (axi_l.b_ready) begin
      b_valid_d = 1'b0;
    end
  end

  // Reads sample regs_q, so a same-cycle write to the slot is not yet visible.
  always_comb begin
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    rd_pulse_d = '0;
    if (ar_hs) begin
      r_valid_d = 1'b1;
      if (r_in_range) begin
        r_resp_d         = OKAY;
        r_data_d         = RO_MASK[ridx] ? hw_arr[ridx] : regs_q[ridx];
        rd_pulse_d[ridx] = 1'b1;
      end else begin
        r_resp_d = SLVERR;
        r_data_d = '0;
      end
    end else if (axi_l.r_ready) begin
      r_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= OKAY;
      r_valid_q  <= 1'b0;
      r_resp_q   <= OKAY;
      r_data_q   <= '0;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      r_valid_q  <= r_valid_d;
      r_resp_q   <= r_resp_d;
      r_data_q   <= r_data_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

  assign axi_l.aw_ready = aw_ready;
  assign axi_l.w_ready  = w_ready;
  assign axi_l.ar_ready = ar_ready;
  assign axi_l.b_valid  = b_valid_q;
  assign axi_l.b_resp   = b_resp_q;
  assign axi_l.r_valid  = r_valid_q;
  assign axi_l.r_resp   = r_resp_q;
  assign axi_l.r_data   = r_data_q;
  assign wr_pulse_o     = wr_pulse_q;
  assign rd_pulse_o     = rd_pulse_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: directed scenarios plus random traffic against an array model.
module tb_axi_lite_regfile;

  localparam logic [1:0]  R_OKAY   = 2'b00;
  localparam logic [1:0]  R_SLVERR = 2'b10;
  localparam logic [31:0] HW7      = 32'h0000_CAFE;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] regs_o;
  logic [255:0] hw_data;
  logic [7:0]   wr_pulse, rd_pulse;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [8];

  AXI_LITE #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  axi_lite_regfile #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .NUM_REGS   (8),
    .RO_MASK    (8'h80)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .axi_l      (bus),
    .regs_o     (regs_o),
    .hw_data_i  (hw_data),
    .wr_pulse_o (wr_pulse),
    .rd_pulse_o (rd_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: 8 words of 4 bytes at 0x00..0x1F, word 7 is a read-only status word.
  function automatic int idx_of(input logic [7:0] addr);
    return (int'(addr) / 4) % 8;
  endfunction

  function automatic bit in_range(input logic [7:0] addr);
    return int'(addr) < 32;
  endfunction

  function automatic bit write_ok(input logic [7:0] addr);
    return in_range(addr) && idx_of(addr) != 7;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [7:0] addr);
    if (!in_range(addr)) return 32'h0;
    if (idx_of(addr) == 7) return HW7;
    return model[idx_of(addr)];
  endfunction

  function automatic logic [7:0] exp_rd_pulse(input logic [7:0] addr);
    return in_range(addr) ? (8'h01 << idx_of(addr)) : 8'h00;
  endfunction

  function automatic logic [7:0] exp_wr_pulse(input logic [7:0] addr);
    return write_ok(addr) ? (8'h01 << idx_of(addr)) : 8'h00;
  endfunction

  function automatic void model_write(input logic [7:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    if (!write_ok(addr)) return;
    for (int k = 0; k < 4; k++)
      if (strb[k]) model[idx_of(addr)][8*k +: 8] = data[8*k +: 8];
  endfunction

  function automatic logic [255:0] model_regs();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 7; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic [7:0] pulse, output int lat);
    bit aw_done, w_done, expired;
    int cyc;
    @(posedge clk); #1;
    bus.aw_addr = addr; bus.aw_valid = 1'b1;
    bus.w_data = data; bus.w_strb = strb; bus.w_valid = 1'b1;
    bus.b_ready = 1'b1;
    aw_done = 0; w_done = 0; cyc = 0; expired = 0;
    resp = 2'bxx; pulse = 8'hxx; lat = -1;
    while (!(aw_done && w_done) && !expired) begin
      @(negedge clk);
      if (bus.aw_valid && bus.aw_ready) aw_done = 1;
      if (bus.w_valid && bus.w_ready) w_done = 1;
      @(posedge clk); #1;
      if (aw_done) bus.aw_valid = 1'b0;
      if (w_done) bus.w_valid = 1'b0;
      if (++cyc > 20) expired = 1;
    end
    cyc = 0;
    while (!expired) begin
      @(negedge clk);
      if (bus.b_valid) begin
        resp = bus.b_resp; pulse = wr_pulse; lat = cyc;
        break;
      end
      if (++cyc > 20) expired = 1;
    end
    if (expired) begin
      checks++; errors++;
      $display("[TB] FAIL write_timeout addr=%h got no B response, required one within 20 cycles", addr);
      bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    end
  endtask

  task automatic do_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp,
                         output logic [7:0] pulse, output int lat);
    bit hs, expired;
    int cyc;
    @(posedge clk); #1;
    bus.ar_addr = addr; bus.ar_valid = 1'b1; bus.r_ready = 1'b1;
    cyc = 0; expired = 0; hs = 0;
    data = 32'hxxxx_xxxx; resp = 2'bxx; pulse = 8'hxx; lat = -1;
    while (!hs && !expired) begin
      @(negedge clk);
      hs = bus.ar_valid && bus.ar_ready;
      @(posedge clk); #1;
      if (hs) bus.ar_valid = 1'b0;
      if (++cyc > 20) expired = 1;
    end
    cyc = 0;
    while (!expired) begin
      @(negedge clk);
      if (bus.r_valid) begin
        data = bus.r_data; resp = bus.r_resp; pulse = rd_pulse; lat = cyc;
        break;
      end
      if (++cyc > 20) expired = 1;
    end
    if (expired) begin
      checks++; errors++;
      $display("[TB] FAIL read_timeout addr=%h got no R response, required one within 20 cycles", addr);
      bus.ar_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; logic [7:0] p; int lat;
    rst = 1'b1;
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1; bus.ar_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.aw_ready, bus.w_ready, bus.ar_ready} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL reset_ready got aw/w/ar=%b required 000", {bus.aw_ready, bus.w_ready, bus.ar_ready});
      end
    end
    checks++;
    if ({bus.b_valid, bus.r_valid, wr_pulse, rd_pulse} !== 18'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got bv=%b rv=%b wp=%h rp=%h required all 0",
               bus.b_valid, bus.r_valid, wr_pulse, rd_pulse);
    end
    checks++;
    if (regs_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_regs got %h required 0", regs_o);
    end
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    for (int i = 0; i < 8; i++) begin
      do_read(8'(4 * i), d, r, p, lat);
      checks++;
      if (d !== exp_rdata(8'(4 * i)) || r !== R_OKAY) begin
        errors++;
        $display("[TB] FAIL reset_read%0d got data=%h resp=%b required data=%h resp=00",
                 i, d, r, exp_rdata(8'(4 * i)));
      end
    end
  endtask

  task automatic test_single_write();
    logic [31:0] d; logic [1:0] r; logic [7:0] p; int lat;
    do_write(8'h08, 32'hDEAD_BEEF, 4'hF, r, p, lat);
    model_write(8'h08, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if (r !== R_OKAY || p !== 8'h04 || lat !== 0) begin
      errors++;
      $display("[TB] FAIL single_write got resp=%b pulse=%h lat=%0d required resp=00 pulse=04 lat=0", r, p, lat);
    end
    @(negedge clk);
    checks++;
    if (wr_pulse !== 8'h00 || bus.b_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_write_pulse_width got pulse=%h bv=%b required 00 and 0", wr_pulse, bus.b_valid);
    end
    do_read(8'h08, d, r, p, lat);
    checks++;
    if (d !== 32'hDEAD_BEEF || r !== R_OKAY || p !== 8'h04 || lat !== 0) begin
      errors++;
      $display("[TB] FAIL single_readback got data=%h resp=%b pulse=%h lat=%0d required deadbeef 00 04 0", d, r, p, lat);
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r; logic [7:0] p; int lat;
    do_write(8'h04, 32'hAAAA_AAAA, 4'hF, r, p, lat);
    model_write(8'h04, 32'hAAAA_AAAA, 4'hF);
    @(posedge clk); #1;
    bus.w_data = 32'h1234_5678; bus.w_strb = 4'h3; bus.w_valid = 1'b1; bus.b_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.w_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL w_first_accept got w_ready=%b required 1", bus.w_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) bus.w_valid = 1'b0;
      if (i == 2) begin bus.aw_addr = 8'h04; bus.aw_valid = 1'b1; end
      @(negedge clk);
      checks++;
      if (bus.w_ready !== 1'b0 || bus.b_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL w_held%0d got w_ready=%b bv=%b required 0 0", i, bus.w_ready, bus.b_valid);
      end
    end
    @(posedge clk); #1;
    bus.aw_valid = 1'b0;
    model_write(8'h04, 32'h1234_5678, 4'h3);
    @(negedge clk);
    checks++;
    if (bus.b_valid !== 1'b1 || bus.b_resp !== R_OKAY || wr_pulse !== 8'h02 || bus.w_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL w_before_aw_commit got bv=%b resp=%b pulse=%h w_ready=%b required 1 00 02 1",
               bus.b_valid, bus.b_resp, wr_pulse, bus.w_ready);
    end
    do_read(8'h04, d, r, p, lat);
    checks++;
    if (d !== 32'hAAAA_5678 || r !== R_OKAY) begin
      errors++;
      $display("[TB] FAIL strobe_merge got data=%h resp=%b required aaaa5678 00", d, r);
    end
  endtask

  task automatic test_b_backpressure();
    @(posedge clk); #1;
    bus.b_ready = 1'b0;
    bus.aw_addr = 8'h0C; bus.aw_valid = 1'b1;
    bus.w_data = 32'h0BAD_F00D; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    @(posedge clk); #1;
    model_write(8'h0C, 32'h0BAD_F00D, 4'hF);
    bus.aw_addr = 8'h10; bus.w_data = 32'h5555_1234;
    @(negedge clk);
    checks++;
    if (bus.b_valid !== 1'b1 || wr_pulse !== 8'h08) begin
      errors++;
      $display("[TB] FAIL bp_first got bv=%b pulse=%h required 1 08", bus.b_valid, wr_pulse);
    end
    @(posedge clk); #1;
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.b_valid !== 1'b1 || bus.aw_ready !== 1'b0 || bus.w_ready !== 1'b0 || wr_pulse !== 8'h00) begin
        errors++;
        $display("[TB] FAIL bp_stall%0d got bv=%b awr=%b wr=%b pulse=%h required 1 0 0 00",
                 i, bus.b_valid, bus.aw_ready, bus.w_ready, wr_pulse);
      end
      @(posedge clk); #1;
    end
    bus.b_ready = 1'b1;
    @(posedge clk); #1;
    model_write(8'h10, 32'h5555_1234, 4'hF);
    @(negedge clk);
    checks++;
    if (bus.b_valid !== 1'b1 || wr_pulse !== 8'h10 || bus.aw_ready !== 1'b1 || regs_o !== model_regs()) begin
      errors++;
      $display("[TB] FAIL bp_second got bv=%b pulse=%h awr=%b regs=%h required 1 10 1 %h",
               bus.b_valid, wr_pulse, bus.aw_ready, regs_o, model_regs());
    end
    @(negedge clk);
    checks++;
    if (bus.b_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drain got bv=%b required 0", bus.b_valid);
    end
  endtask

  task automatic test_ro_and_range();
    logic [31:0] d; logic [1:0] r; logic [7:0] p; int lat;
    logic [7:0] waddrs [2];
    logic [7:0] raddrs [2];
    waddrs[0] = 8'h40; waddrs[1] = 8'h1C;
    raddrs[0] = 8'h1C; raddrs[1] = 8'h40;
    for (int i = 0; i < 2; i++) begin
      do_write(waddrs[i], 32'hFFFF_FFFF, 4'hF, r, p, lat);
      checks++;
      if (r !== R_SLVERR || p !== 8'h00 || regs_o !== model_regs()) begin
        errors++;
        $display("[TB] FAIL bad_write_%h got resp=%b pulse=%h regs=%h required 10 00 %h",
                 waddrs[i], r, p, regs_o, model_regs());
      end
    end
    for (int i = 0; i < 2; i++) begin
      do_read(raddrs[i], d, r, p, lat);
      checks++;
      if (d !== exp_rdata(raddrs[i]) || r !== (in_range(raddrs[i]) ? R_OKAY : R_SLVERR) ||
          p !== exp_rd_pulse(raddrs[i])) begin
        errors++;
        $display("[TB] FAIL ro_range_read_%h got data=%h resp=%b pulse=%h required %h %b %h",
                 raddrs[i], d, r, p, exp_rdata(raddrs[i]),
                 in_range(raddrs[i]) ? R_OKAY : R_SLVERR, exp_rd_pulse(raddrs[i]));
      end
    end
    do_write(8'h0C, 32'h1357_9BDF, 4'h0, r, p, lat);
    checks++;
    if (r !== R_OKAY || p !== 8'h08 || regs_o !== model_regs()) begin
      errors++;
      $display("[TB] FAIL zero_strobe got resp=%b pulse=%h regs=%h required 00 08 %h", r, p, regs_o, model_regs());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] old5, d;
    logic [7:0]  a;
    @(posedge clk); #1;
    bus.b_ready = 1'b1; bus.r_ready = 1'b1; bus.w_strb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      bus.aw_addr = 8'(4 * i); bus.w_data = $urandom;
      bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.aw_ready !== 1'b1 || bus.w_ready !== 1'b1 ||
          (i > 0 && (bus.b_valid !== 1'b1 || wr_pulse !== (8'h01 << (i - 1))))) begin
        errors++;
        $display("[TB] FAIL b2b_write%0d got awr=%b wr=%b bv=%b pulse=%h", i, bus.aw_ready, bus.w_ready,
                 bus.b_valid, wr_pulse);
      end
      @(posedge clk); #1;
      model_write(8'(4 * i), bus.w_data, 4'hF);
    end
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.b_valid !== 1'b1 || wr_pulse !== 8'h08 || regs_o !== model_regs()) begin
      errors++;
      $display("[TB] FAIL b2b_write_last got bv=%b pulse=%h regs=%h required 1 08 %h",
               bus.b_valid, wr_pulse, regs_o, model_regs());
    end
    a = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) begin bus.ar_addr = 8'(4 * i + 4); bus.ar_valid = 1'b1; end
      else bus.ar_valid = 1'b0;
      if (i > 0) begin
        @(negedge clk);
        checks++;
        if (bus.r_valid !== 1'b1 || bus.r_data !== exp_rdata(a) || rd_pulse !== exp_rd_pulse(a)) begin
          errors++;
          $display("[TB] FAIL b2b_read%0d got rv=%b data=%h pulse=%h required 1 %h %h",
                   i, bus.r_valid, bus.r_data, rd_pulse, exp_rdata(a), exp_rd_pulse(a));
        end
      end
      a = bus.ar_addr;
    end
    old5 = model[5];
    d = $urandom;
    @(posedge clk); #1;
    bus.aw_addr = 8'h14; bus.ar_addr = 8'h14; bus.w_data = d;
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1; bus.ar_valid = 1'b1;
    @(posedge clk); #1;
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    model_write(8'h14, d, 4'hF);
    @(negedge clk);
    checks++;
    if (bus.r_data !== old5 || bus.b_resp !== R_OKAY || regs_o[5*32 +: 32] !== d) begin
      errors++;
      $display("[TB] FAIL same_cycle_rw got rdata=%h resp=%b reg5=%h required %h 00 %h",
               bus.r_data, bus.b_resp, regs_o[5*32 +: 32], old5, d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, wd; logic [1:0] r; logic [7:0] p, a; logic [3:0] s; int lat;
    for (int n = 0; n < 120; n++) begin
      a = 8'($urandom_range(0, 8'h4F));
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom; s = 4'($urandom);
        do_write(a, wd, s, r, p, lat);
        model_write(a, wd, s);
        checks++;
        if (r !== (write_ok(a) ? R_OKAY : R_SLVERR) || p !== exp_wr_pulse(a) || lat !== 0 ||
            regs_o !== model_regs()) begin
          errors++;
          $display("[TB] FAIL rand_write n=%0d addr=%h got resp=%b pulse=%h lat=%0d required %b %h 0",
                   n, a, r, p, lat, write_ok(a) ? R_OKAY : R_SLVERR, exp_wr_pulse(a));
        end
      end else begin
        do_read(a, d, r, p, lat);
        checks++;
        if (d !== exp_rdata(a) || r !== (in_range(a) ? R_OKAY : R_SLVERR) ||
            p !== exp_rd_pulse(a) || lat !== 0) begin
          errors++;
          $display("[TB] FAIL rand_read n=%0d addr=%h got data=%h resp=%b pulse=%h required %h %b %h",
                   n, a, d, r, p, exp_rdata(a), in_range(a) ? R_OKAY : R_SLVERR, exp_rd_pulse(a));
        end
      end
    end
  endtask

  task automatic test_read_stall_reset();
    logic [31:0] exp;
    exp = exp_rdata(8'h08);
    @(posedge clk); #1;
    bus.r_ready = 1'b0; bus.ar_addr = 8'h08; bus.ar_valid = 1'b1;
    @(posedge clk); #1;
    bus.ar_addr = 8'h0C;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.r_valid !== 1'b1 || bus.r_data !== exp || bus.r_resp !== R_OKAY || bus.ar_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL r_stall%0d got rv=%b data=%h resp=%b arr=%b required 1 %h 00 0",
                 i, bus.r_valid, bus.r_data, bus.r_resp, bus.ar_ready, exp);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1; bus.ar_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) model[i] = '0;
    @(negedge clk);
    checks++;
    if (bus.r_valid !== 1'b0 || regs_o !== '0 || bus.aw_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_reset got rv=%b regs=%h awr=%b required 0 0 0", bus.r_valid, regs_o, bus.aw_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.r_ready = 1'b1;
  endtask

  initial begin
    bus.aw_addr = '0; bus.aw_valid = 1'b0; bus.w_data = '0; bus.w_strb = '0; bus.w_valid = 1'b0;
    bus.b_ready = 1'b0; bus.ar_addr = '0; bus.ar_valid = 1'b0; bus.r_ready = 1'b0;
    for (int i = 0; i < 8; i++) hw_data[32*i +: 32] = 32'h1111_0000 | 32'(i);
    hw_data[7*32 +: 32] = HW7;
    test_reset();
    test_single_write();
    test_w_before_aw();
    test_b_backpressure();
    test_ro_and_range();
    test_back_to_back();
    test_random();
    test_read_stall_reset();
    test_single_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
